// File: rtl/systolic_matmul_core.sv
// Output-stationary N x N systolic matrix-multiply core with skewed A/B feeds.
// Optional macro SYSTOLIC_ACCUM_EN adds the accumulate port for K tiling.
module systolic_matmul_core #(
  parameter int DATA_WIDTH = 8,
  parameter int N          = 4,
  parameter int K_MAX      = 16,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(K_MAX)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [$clog2(K_MAX):0]       k_len,
`ifdef SYSTOLIC_ACCUM_EN
  input  logic                         accumulate,
`endif
  input  logic [N*DATA_WIDTH-1:0]      a_in,
  input  logic [N*DATA_WIDTH-1:0]      b_in,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [N*N*ACC_WIDTH-1:0]     c_out,
  output logic                         busy,
  output logic                         done,
  output logic                         out_valid
);

  localparam int KW  = $clog2(K_MAX) + 1;
  localparam int DCW = $clog2(2*N);
  localparam int SK  = N*(N-1)/2;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]     state;
  logic [KW-1:0]  k_lat;
  logic [KW-1:0]  bcnt;
  logic [DCW-1:0] dcnt;
  logic [KW-1:0]  klen_c;
  logic           accept;
  logic           run;
  logic           keep;

  logic signed [DATA_WIDTH-1:0]   a_inj  [N];
  logic signed [DATA_WIDTH-1:0]   b_inj  [N];
  logic signed [DATA_WIDTH-1:0]   a_edge [N];
  logic signed [DATA_WIDTH-1:0]   b_edge [N];
  // Skew delay lines packed triangularly: row/column i owns i entries starting at i*(i-1)/2.
  logic signed [DATA_WIDTH-1:0]   a_sk   [SK];
  logic signed [DATA_WIDTH-1:0]   b_sk   [SK];
  logic signed [DATA_WIDTH-1:0]   a_pipe [N][N-1];
  logic signed [DATA_WIDTH-1:0]   b_pipe [N-1][N];
  logic signed [DATA_WIDTH-1:0]   a_x    [N][N];
  logic signed [DATA_WIDTH-1:0]   b_x    [N][N];
  logic signed [2*DATA_WIDTH-1:0] prod   [N][N];
  logic signed [ACC_WIDTH-1:0]    acc    [N][N];

`ifdef SYSTOLIC_ACCUM_EN
  assign keep = accumulate;
`else
  assign keep = 1'b0;
`endif

  assign klen_c    = (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;
  assign accept    = in_valid && (state == S_STREAM);
  assign run       = (state == S_STREAM) || (state == S_DRAIN);
  assign in_ready  = (state == S_STREAM);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      a_inj[i] = accept ? a_in[i*DATA_WIDTH +: DATA_WIDTH] : '0;
      b_inj[i] = accept ? b_in[i*DATA_WIDTH +: DATA_WIDTH] : '0;
    end
    a_edge[0] = a_inj[0];
    b_edge[0] = b_inj[0];
    for (int unsigned i = 1; i < N; i++) begin
      a_edge[i] = a_sk[i*(i-1)/2 + i - 1];
      b_edge[i] = b_sk[i*(i-1)/2 + i - 1];
    end
    for (int unsigned i = 0; i < N; i++) begin
      a_x[i][0] = a_edge[i];
      b_x[0][i] = b_edge[i];
      for (int unsigned j = 1; j < N; j++) begin
        a_x[i][j] = a_pipe[i][j-1];
        b_x[j][i] = b_pipe[j-1][i];
      end
    end
    for (int unsigned i = 0; i < N; i++)
      for (int unsigned j = 0; j < N; j++)
        prod[i][j] = a_x[i][j] * b_x[i][j];
  end

  always_comb begin
    c_out = '0;
    for (int unsigned i = 0; i < N; i++)
      for (int unsigned j = 0; j < N; j++)
        c_out[(i*N+j)*ACC_WIDTH +: ACC_WIDTH] = acc[i][j];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      k_lat     <= '0;
      bcnt      <= '0;
      dcnt      <= '0;
      out_valid <= 1'b0;
      for (int unsigned s = 0; s < SK; s++) begin
        a_sk[s] <= '0;
        b_sk[s] <= '0;
      end
      for (int unsigned i = 0; i < N; i++)
        for (int unsigned j = 0; j < N; j++)
          acc[i][j] <= '0;
      for (int unsigned i = 0; i < N; i++)
        for (int unsigned j = 0; j < N-1; j++) begin
          a_pipe[i][j] <= '0;
          b_pipe[j][i] <= '0;
        end
    end else begin
      for (int unsigned i = 1; i < N; i++) begin
        a_sk[i*(i-1)/2] <= a_inj[i];
        b_sk[i*(i-1)/2] <= b_inj[i];
        for (int unsigned d = 1; d < i; d++) begin
          a_sk[i*(i-1)/2 + d] <= a_sk[i*(i-1)/2 + d - 1];
          b_sk[i*(i-1)/2 + d] <= b_sk[i*(i-1)/2 + d - 1];
        end
      end
      for (int unsigned i = 0; i < N; i++)
        for (int unsigned j = 0; j < N-1; j++) begin
          a_pipe[i][j] <= a_x[i][j];
          b_pipe[j][i] <= b_x[j][i];
        end
      if (run)
        for (int unsigned i = 0; i < N; i++)
          for (int unsigned j = 0; j < N; j++)
            acc[i][j] <= acc[i][j] + ACC_WIDTH'(prod[i][j]);

      case (state)
        S_IDLE: if (start) begin
          k_lat <= klen_c;
          bcnt  <= '0;
          if (!keep)
            for (int unsigned i = 0; i < N; i++)
              for (int unsigned j = 0; j < N; j++)
                acc[i][j] <= '0;
          if (klen_c == '0) begin
            state     <= S_DONE;
            out_valid <= 1'b1;
          end else begin
            state     <= S_STREAM;
            out_valid <= 1'b0;
          end
        end
        S_STREAM: if (accept) begin
          bcnt <= bcnt + KW'(1);
          if (bcnt + KW'(1) == k_lat) begin
            state <= S_DRAIN;
            dcnt  <= '0;
          end
        end
        S_DRAIN: begin
          // Last product reaches PE(N-1,N-1) 2N-2 cycles after the final beat.
          if (dcnt == DCW'(2*N-2)) begin
            state     <= S_DONE;
            out_valid <= 1'b1;
          end else begin
            dcnt <= dcnt + DCW'(1);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/systolic_matmul_core.md
SYSTOLIC_MATMUL_CORE -- requirements
Module: systolic_matmul_core

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, signed operand width.
REQ-002 SHALL have parameter N, default 4, array dimension (N x N PEs), legal 2..8.
REQ-003 SHALL have parameter K_MAX, default 16, maximum stream length per job.
REQ-004 SHALL have parameter ACC_WIDTH, default 2*DATA_WIDTH+$clog2(K_MAX), accumulator width.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port start  input  1  job request, sampled in IDLE only.
REQ-008 SHALL have port k_len  input  $clog2(K_MAX)+1  beats in the job, sampled with start.
REQ-009 SHALL have port a_in  input  N*DATA_WIDTH  one column of A; row i at [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 SHALL have port b_in  input  N*DATA_WIDTH  one row of B; column j at [j*DATA_WIDTH +: DATA_WIDTH].
REQ-011 SHALL have port in_valid  input  1  a_in/b_in hold a beat.
REQ-012 SHALL have port in_ready  output  1  core accepts a beat this cycle.
REQ-013 SHALL have port c_out  output  N*N*ACC_WIDTH  result; C[i][j] at [(i*N+j)*ACC_WIDTH +: ACC_WIDTH].
REQ-014 SHALL have port busy  output  1  high in any state except IDLE.
REQ-015 SHALL have port done  output  1  single-cycle completion pulse.
REQ-016 SHALL have port out_valid  output  1  c_out holds a completed result.

Function
REQ-017 SHALL implement FSM IDLE -> STREAM -> DRAIN -> DONE -> IDLE.
REQ-018 IDLE: start=1 SHALL latch k_len, clear all accumulators and out_valid, and go to STREAM; start in other states SHALL be ignored.
REQ-019 k_len=0 SHALL go IDLE -> DONE directly with all-zero c_out; k_len>K_MAX SHALL be clamped to K_MAX.
REQ-020 in_ready SHALL be 1 only in STREAM; a beat is accepted on a clock edge with in_valid & in_ready.
REQ-021 Row i of A SHALL be delayed i cycles and column j of B j cycles by skew registers; PE(i,j) passes a right and b down through one register each.
REQ-022 Each cycle without an accepted beat in STREAM or DRAIN SHALL inject zeros into all skew inputs (bubble), leaving results unchanged.
REQ-023 PE(i,j) SHALL compute acc += sign-extended signed(a)*signed(b), wrapping modulo 2^ACC_WIDTH.
REQ-024 STREAM SHALL go to DRAIN on the edge accepting beat k_len.
REQ-025 DRAIN SHALL last exactly 2N-1 cycles, then go to DONE.
REQ-026 DONE SHALL last one cycle with done=1 and out_valid set, then go to IDLE.
REQ-027 C = A x B SHALL be visible on c_out from the DONE cycle until the next accepted start.

Reset
REQ-028 rst=0 SHALL asynchronously force IDLE, clear all accumulators, skew and PE registers, and drive c_out=0, in_ready=0, busy=0, done=0, out_valid=0.
REQ-029 Reset mid-job SHALL abort the job with no done pulse; the first start after release SHALL behave as from power-up.

Configuration
REQ-030 With macro SYSTOLIC_ACCUM_EN defined, the core SHALL add input port accumulate (1 bit, sampled with start); accumulate=1 SHALL skip the accumulator clear so results sum across jobs (K tiling).
REQ-031 Without SYSTOLIC_ACCUM_EN, the port SHALL be absent and every start SHALL clear the accumulators.

Verification
REQ-032 N=2: reset, start with k_len=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], in_valid held high -> done 2N-1+1 cycles after the last beat; c_out = [19,22,43,50].
REQ-033 Same job with in_valid low for 3 cycles between beats -> identical c_out; in_ready high throughout STREAM.
REQ-034 Signed operands: A=[[-128,0],[0,-1]], B=[[-128,0],[0,127]], k_len=2 -> C[0][0]=16384, C[1][1]=-127, C[0][1]=C[1][0]=0.
REQ-035 rst pulsed low during DRAIN -> all outputs 0 immediately, no done; a new job then produces correct results.
REQ-036 k_len=0 -> done on the cycle after start with c_out=0; start asserted during STREAM -> ignored.
REQ-037 With SYSTOLIC_ACCUM_EN: REQ-032 job then repeated with accumulate=1 -> c_out = [38,44,86,100].
